// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared types and default width for the accumulator unit.
//  Revision    : 1.0
// ============================================================================
package accum_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        CLR  = 2'b00,
        ADD  = 2'b01,
        SUB  = 2'b10,
        SUB2 = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/accum_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : accum_unit_if
//  Description : Command and response handshake bundle of the accumulator.
//  Revision    : 1.0
// ============================================================================
interface accum_unit_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_acc;
    logic         rsp_carry;
    logic         rsp_ovf;
    logic         rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_acc, rsp_carry, rsp_ovf, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_acc, rsp_carry, rsp_ovf, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/addsub_w.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_w
//  Description : Combinational ripple-carry adder/subtractor with flags.
//  Revision    : 1.0
// ============================================================================
module addsub_w #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_s,
    output logic         o_c_out,
    output logic         o_ovf
);
    logic [W-1:0] w_b_eff;
    logic         w_carry;

    assign w_b_eff = i_b ^ {W{i_sub}};

    // Subtraction is a + ~b + 1, the +1 entering as the chain's carry-in.
    always_comb begin
        o_s     = '0;
        w_carry = i_sub;
        for (int i = 0; i < W; i++) begin
            o_s[i]  = i_a[i] ^ w_b_eff[i] ^ w_carry;
            w_carry = (i_a[i] & w_b_eff[i]) | (w_carry & (i_a[i] ^ w_b_eff[i]));
        end
        o_c_out = w_carry;
    end

    assign o_ovf = (i_a[W-1] == w_b_eff[W-1]) & (o_s[W-1] != i_a[W-1]);
endmodule
`default_nettype wire

// File: rtl/accum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : accum_unit
//  Description : Command-driven accumulator (clear/add/sub/double-sub) with
//                valid/ready command and response handshakes.
//  Revision    : 1.0
// ============================================================================
module accum_unit
    import accum_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    accum_unit_if.slave  bus
);
    state_e       r_state;
    state_e       w_state_nxt;
    op_e          r_op;
    logic [W-1:0] r_data;
    logic [W-1:0] r_acc;
    logic         r_carry;
    logic         r_ovf;

    logic         w_accept;
    op_e          w_cmd_op;
    logic         w_sub;
    logic [W-1:0] w_sum;
    logic         w_cout;
    logic         w_ovf;

    assign w_cmd_op = op_e'(bus.cmd_op);
    assign w_accept = bus.cmd_valid & (r_state == IDLE);
    assign w_sub    = (r_op != ADD);

    // Single adder shared by both passes; operands always come from registers.
    addsub_w #(.W(W)) u_addsub (
        .i_a     (r_acc),
        .i_b     (r_data),
        .i_sub   (w_sub),
        .o_s     (w_sum),
        .o_c_out (w_cout),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_cmd_op == CLR) ? RESP : PASS1;
            PASS1:   w_state_nxt = (r_op == SUB2) ? PASS2 : RESP;
            PASS2:   w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= CLR;
            r_data  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= w_cmd_op;
                        r_data <= bus.cmd_data;
                        if (w_cmd_op == CLR) begin
                            r_acc   <= '0;
                            r_carry <= 1'b0;
                            r_ovf   <= 1'b0;
                        end
                    end
                end
                PASS1: begin
                    r_acc   <= w_sum;
                    r_carry <= w_cout;
                    r_ovf   <= w_ovf;
                end
                PASS2: begin
                    // Borrow in either pass clears carry; overflow is sticky.
                    r_acc   <= w_sum;
                    r_carry <= r_carry & w_cout;
                    r_ovf   <= r_ovf | w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_acc   = r_acc;
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_ovf   = r_ovf;
    assign bus.rsp_zero  = (r_acc == '0);
endmodule
`default_nettype wire

// File: tb/tb_accum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_unit
//  Description : Directed and randomized self-checking bench for accum_unit.
//  Revision    : 1.0
// ============================================================================
module tb_accum_unit;
    import accum_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   m_acc;
    logic m_carry;
    logic m_ovf;

    accum_unit_if #(.W(16)) bus ();

    accum_unit #(.W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic out_of_range(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference: plain integer arithmetic on the accumulator value.
    task automatic model_sub(input logic [15:0] d, output logic c, output logic o);
        c     = (m_acc >= int'(d));
        o     = out_of_range(s16(m_acc[15:0]) - s16(d));
        m_acc = (m_acc - int'(d) + 65536) % 65536;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [15:0] d);
        logic c1, o1, c2, o2;
        case (op)
            2'b00: begin m_acc = 0; m_carry = 1'b0; m_ovf = 1'b0; end
            2'b01: begin
                m_carry = (m_acc + int'(d)) > 65535;
                m_ovf   = out_of_range(s16(m_acc[15:0]) + s16(d));
                m_acc   = (m_acc + int'(d)) % 65536;
            end
            2'b10: begin model_sub(d, c1, o1); m_carry = c1; m_ovf = o1; end
            default: begin
                model_sub(d, c1, o1);
                model_sub(d, c2, o2);
                m_carry = c1 & c2;
                m_ovf   = o1 | o2;
            end
        endcase
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input int hold);
        int           n;
        int           exp_lat;
        logic [15:0]  held_acc;
        check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = 16'($urandom);
        bus.rsp_ready = (hold == 0);
        model_apply(op, d);
        exp_lat = (op == 2'b00) ? 1 : (op == 2'b11) ? 3 : 2;
        n = 1;
        while (!bus.rsp_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, exp_lat);
        check("rsp_acc", {16'd0, bus.rsp_acc}, m_acc);
        check("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, m_carry});
        check("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, m_ovf});
        check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, (m_acc == 0)});
        held_acc = bus.rsp_acc;
        for (int k = 0; k < hold; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_data  = 16'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("hold_acc", {16'd0, bus.rsp_acc}, {16'd0, held_acc});
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] d;
        checks        = 0;
        errors        = 0;
        m_acc         = 0;
        m_carry       = 1'b0;
        m_ovf         = 1'b0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_acc", {16'd0, bus.rsp_acc}, 32'd0);
        check("rst_zero", {31'd0, bus.rsp_zero}, 32'd1);
        check("rst_carry", {31'd0, bus.rsp_carry}, 32'd0);
        check("rst_ovf", {31'd0, bus.rsp_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_cmd(2'b00, 16'h0000, 0);
        do_cmd(2'b01, 16'h7FFF, 0);
        do_cmd(2'b01, 16'h0001, 0);
        do_cmd(2'b00, 16'h0000, 0);
        do_cmd(2'b01, 16'h0001, 0);
        do_cmd(2'b01, 16'hFFFF, 0);
        do_cmd(2'b00, 16'h0000, 0);
        do_cmd(2'b01, 16'h0003, 0);
        do_cmd(2'b10, 16'h0005, 0);
        do_cmd(2'b00, 16'h0000, 0);
        do_cmd(2'b01, 16'h0010, 0);
        do_cmd(2'b11, 16'h0003, 0);
        do_cmd(2'b00, 16'h0000, 0);
        do_cmd(2'b01, 16'h0004, 0);
        do_cmd(2'b11, 16'h0003, 5);

        do_cmd(2'b01, 16'h1234, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 16'h0101;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("midrst_acc", {16'd0, bus.rsp_acc}, 32'd0);
        check("midrst_zero", {31'd0, bus.rsp_zero}, 32'd1);
        m_acc   = 0;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            d  = 16'($urandom);
            do_cmd(op, d, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
